lcd_bus_sequencer: RTL and testbench
====================================

// Module: lcd_bus_sequencer
// PURPOSE
//  Consumes the 32-bit LCD buffer word (b_io_lcd) written by software through the MMIO store path.
//  Turns each new {RS,DATA} value into one HD44780-style bus write: setup, EN pulse, hold, exec wait.
//  Keeps a 1-entry pending slot; counts overwritten (dropped) requests. Drives the LCD pins directly.
// PARAMETERS
//  T_SETUP  2     cycles RS/DATA stable before EN rises (>=1)
//  T_PULSE  12    cycles EN high (>=1)
//  T_HOLD   2     cycles RS/DATA held after EN falls (>=1)
//  T_EXEC   2000  cycles idle wait after HOLD for LCD command execution (>=1)
//  CNT_W    16    width of phase counter; every T_* < 2**CNT_W
// PORTS
//  i_clk        in   1   clock
//  i_reset      in   1   asynchronous, active-low reset
//  i_lcd_word   in   32  [31]=ON, [9]=GO toggle, [8]=RS, [7:0]=DATA; other bits ignored
//  o_lcd_on     out  1   LCD power/backlight enable
//  o_lcd_en     out  1   LCD enable strobe
//  o_lcd_rs     out  1   LCD register select
//  o_lcd_rw     out  1   LCD read/write; constant 0 (write only)
//  o_lcd_data   out  8   LCD data bus
//  o_busy       out  1   1 whenever FSM is not in IDLE
//  o_drop_cnt   out  8   saturating count of pending requests overwritten before service
// BEHAVIOUR
//  Reset (async, any state):
//   - All outputs 0.
//   - FSM=IDLE, counter=0, pending empty, last_seen[9:0]=0.
//  Change detect: chg = (i_lcd_word[9:0] != last_seen).
//   - last_seen <= i_lcd_word[9:0] every cycle.
//   - GO toggle lets software resend an identical char.
//  o_lcd_on <= i_lcd_word[31] every cycle (1-cycle latency, independent of FSM).
//  FSM states:
//   - IDLE:
//     - chg -> load act_rs/act_data from word; SETUP, cnt=0.
//     - Outputs rs/data update at the same edge, so a change seen at edge N drives pins from edge N+1.
//   - SETUP: en=0 for T_SETUP cycles -> PULSE.
//   - PULSE: en=1 for T_PULSE cycles -> HOLD.
//   - HOLD:  en=0, rs/data held, T_HOLD cycles -> WAIT.
//   - WAIT:  en=0, T_EXEC cycles. At the last cycle:
//     - pending or chg: load newest request, SETUP.
//     - else: IDLE.
//   - Each phase lasts exactly its T_* cycles. cnt counts 0..T-1 and clears on each transition.
//   - Busy span per write = T_SETUP+T_PULSE+T_HOLD+T_EXEC cycles.
//   - Back-to-back writes have no IDLE gap.
//  Pending slot (states != IDLE):
//   - chg -> pend <= {RS,DATA}, pend_v <= 1.
//   - If pend_v was already 1: o_drop_cnt += 1, saturating at 255.
//   - chg on the last WAIT cycle: the new word wins (pass-through).
//     - If pend_v was also set: that older entry counts as dropped.
//   - pend_v clears when the request is loaded into SETUP.
//  o_lcd_rs/o_lcd_data always equal act_rs/act_data; never change outside an IDLE->SETUP or WAIT->SETUP edge.
//  ON bit and ignored bits never trigger a transaction.
//  Reset mid-transaction aborts the transaction: EN drops to 0 immediately, pending lost.
//  If i_lcd_word[9:0] != 0 when reset releases, a transaction starts (last_seen reset to 0).
// TESTING (T_SETUP=1, T_PULSE=3, T_HOLD=1, T_EXEC=4)
//  1. Reset; word=0x0000_0141 -> edge+1: rs=1, data=0x41, busy=1.
//     - en=1 for exactly 3 cycles, starting 1 cycle after SETUP.
//     - busy for 9 cycles, then IDLE.
//  2. Write 0x141, then 0x341 (GO toggle, same char) after idle -> two identical EN pulses.
//     - Word 0x8000_0141 only toggles o_lcd_on: no pulse.
//  3. During busy, write 0x142 then 0x143:
//     - One follow-up transaction carrying data=0x43.
//     - o_drop_cnt=1; no IDLE cycle between transactions.
//  4. Change on the last WAIT cycle -> next edge enters SETUP with the new data; o_busy stays 1.
//  5. Assert i_reset during PULSE -> en, busy, data go 0 asynchronously.
//     - Release with word=0x155 -> new transaction with data=0x55.
//  6. 300 overwrites while busy -> o_drop_cnt saturates at 255; o_lcd_rw is 0 throughout.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// HD44780-style write sequencer fed by the software-written LCD buffer word.
// Each new {RS,DATA} (or GO toggle) becomes one setup/EN-pulse/hold/exec-wait bus write.
module lcd_bus_sequencer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt
);

  localparam int unsigned REQ_W  = 9;
  localparam int unsigned SEEN_W = 10;
  localparam int unsigned DROP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEEN_W-1:0]   last_seen_q, last_seen_d;
  logic [REQ_W-1:0]    act_q, act_d;
  logic [REQ_W-1:0]    pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                on_q, on_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;

  logic                chg_c;
  logic [REQ_W-1:0]    req_c;
  logic                word_unused_c;

  assign chg_c         = (i_lcd_word[SEEN_W-1:0] != last_seen_q);
  assign req_c         = i_lcd_word[REQ_W-1:0];
  assign word_unused_c = ^i_lcd_word[30:10];

  // Next-state, pending slot and drop accounting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    last_seen_d = i_lcd_word[SEEN_W-1:0];
    act_d       = act_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    drop_d      = drop_q;
    on_d        = i_lcd_word[31];

    // A change while busy with an occupied slot always loses the older request
    if ((state_q != S_IDLE) && chg_c && pend_v_q && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (chg_c) begin
          act_d   = req_c;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(T_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == CNT_W'(T_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(T_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(T_EXEC - 1)) begin
          cnt_d = '0;
          if (chg_c) begin
            act_d    = req_c;
            pend_v_d = 1'b0;
            state_d  = S_SETUP;
          end else if (pend_v_q) begin
            act_d    = pend_q;
            pend_v_d = 1'b0;
            state_d  = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Park changes in the slot unless they are passed straight through above
    if ((state_q != S_IDLE) && chg_c &&
        !((state_q == S_WAIT) && (cnt_q == CNT_W'(T_EXEC - 1)))) begin
      pend_d   = req_c;
      pend_v_d = 1'b1;
    end

    en_d   = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_seen_q <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      drop_q      <= '0;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      drop_q      <= drop_d;
      on_q        <= on_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
    end
  end

  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = act_q[8];
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = act_q[7:0];
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: directed scenarios plus random word traffic,
// compared against a transaction-timeline model of the LCD write protocol.
module tb_lcd_bus_sequencer;

  localparam int TS    = 1;
  localparam int TP    = 3;
  localparam int TH    = 1;
  localparam int TE    = 4;
  localparam int TOTAL = TS + TP + TH + TE;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_lcd_word;
  logic        o_lcd_on;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int busy_cnt = 0;

  // Model: one active write positioned at time m_t within its TOTAL-cycle span
  bit       m_active;
  int       m_t;
  bit [8:0] m_act;
  bit [8:0] m_pend;
  bit       m_pv;
  int       m_drop;
  bit [9:0] m_last;
  bit       m_on;

  lcd_bus_sequencer #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .CNT_W(16)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_lcd_word (i_lcd_word),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data),
    .o_busy     (o_busy),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_act    = '0;
    m_pend   = '0;
    m_pv     = 1'b0;
    m_drop   = 0;
    m_last   = '0;
    m_on     = 1'b0;
  endtask

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_edge(input logic [31:0] w);
    bit chg;
    chg  = (w[9:0] != m_last);
    m_on = w[31];
    if (!m_active) begin
      if (chg) begin
        m_active = 1'b1;
        m_t      = 0;
        m_act    = w[8:0];
      end
    end else if (m_t == TOTAL - 1) begin
      if (chg) begin
        if (m_pv) bump_drop();
        m_act = w[8:0];
        m_pv  = 1'b0;
        m_t   = 0;
      end else if (m_pv) begin
        m_act = m_pend;
        m_pv  = 1'b0;
        m_t   = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
      if (chg) begin
        if (m_pv) bump_drop();
        m_pend = w[8:0];
        m_pv   = 1'b1;
      end
    end
    m_last = w[9:0];
  endtask

  task automatic check_all();
    bit exp_en;
    exp_en = m_active && (m_t >= TS) && (m_t < TS + TP);
    chk("on",   32'(o_lcd_on),   32'(m_on));
    chk("en",   32'(o_lcd_en),   32'(exp_en));
    chk("rs",   32'(o_lcd_rs),   32'(m_act[8]));
    chk("rw",   32'(o_lcd_rw),   32'h0);
    chk("data", 32'(o_lcd_data), 32'(m_act[7:0]));
    chk("busy", 32'(o_busy),     32'(m_active));
    chk("drop", 32'(o_drop_cnt), 32'(m_drop));
  endtask

  task automatic step(input logic [31:0] w);
    i_lcd_word = w;
    @(posedge i_clk);
    model_edge(w);
    #1;
    check_all();
    if (o_lcd_en) en_cnt++;
    if (o_busy) busy_cnt++;
  endtask

  initial begin
    logic [31:0] cur;
    int          r;

    // Reset state
    i_reset    = 1'b0;
    i_lcd_word = 32'h0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all();
    #3 i_reset = 1'b1;

    // 1: single write, EN width and busy span
    en_cnt = 0; busy_cnt = 0;
    step(32'h0000_0141);
    chk("t1_rs", 32'(o_lcd_rs), 32'h1);
    chk("t1_data", 32'(o_lcd_data), 32'h41);
    chk("t1_busy", 32'(o_busy), 32'h1);
    repeat (12) step(32'h0000_0141);
    chk("t1_en_cycles", 32'(en_cnt), 32'd3);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd9);

    // 2: GO toggle resends same char; ON bit alone triggers nothing
    en_cnt = 0;
    repeat (12) step(32'h0000_0341);
    chk("t2_go_en_cycles", 32'(en_cnt), 32'd3);
    en_cnt = 0; busy_cnt = 0;
    repeat (5) step(32'h8000_0341);
    chk("t2_on_en_cycles", 32'(en_cnt), 32'd0);
    chk("t2_on_busy_cycles", 32'(busy_cnt), 32'd0);
    chk("t2_on", 32'(o_lcd_on), 32'h1);

    // 3: overwrite in pending slot, seamless follow-up
    busy_cnt = 0;
    step(32'h0000_0140);
    step(32'h0000_0142);
    step(32'h0000_0143);
    chk("t3_drop", 32'(o_drop_cnt), 32'd1);
    repeat (6) step(32'h0000_0143);
    step(32'h0000_0143);
    chk("t3_followup_data", 32'(o_lcd_data), 32'h43);
    repeat (10) step(32'h0000_0143);
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd18);

    // 4: change on the last WAIT cycle passes straight through
    repeat (9) step(32'h0000_01AA);
    step(32'h0000_00BB);
    chk("t4_data", 32'(o_lcd_data), 32'hBB);
    chk("t4_rs", 32'(o_lcd_rs), 32'h0);
    chk("t4_busy", 32'(o_busy), 32'h1);
    repeat (10) step(32'h0000_00BB);

    // 5: asynchronous reset during PULSE
    step(32'h0000_01CC);
    step(32'h0000_01CC);
    step(32'h0000_01CC);
    chk("t5_en_before", 32'(o_lcd_en), 32'h1);
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_en", 32'(o_lcd_en), 32'h0);
    chk("t5_rst_busy", 32'(o_busy), 32'h0);
    chk("t5_rst_data", 32'(o_lcd_data), 32'h0);
    chk("t5_rst_rs", 32'(o_lcd_rs), 32'h0);
    i_lcd_word = 32'h0000_0155;
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b1;
    step(32'h0000_0155);
    chk("t5_data", 32'(o_lcd_data), 32'h55);
    chk("t5_busy", 32'(o_busy), 32'h1);

    // 6: saturating drop counter
    for (int i = 1; i <= 310; i++) step(32'(i % 512));
    chk("t6_drop_sat", 32'(o_drop_cnt), 32'd255);
    cur = 32'(310);

    // Random traffic, including ON-only and ignored-bit changes
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    cur = $urandom;
        2:       cur = cur ^ 32'h8000_0000;
        3:       cur = cur ^ 32'h0010_0000;
        default: cur = cur;
      endcase
      step(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
